// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: tag values, request bus
// layout and grant FSM states.
package sram_bus_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam int SRAM_REQ_BUS_W = 71;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_t;

    // Field order matches the bus width above: wr, size, wstrb, addr, wdata.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// DEPTH x 1-bit in-order tag FIFO. Push while full and pop while empty are
// ignored, so the owner may present raw requests.
module sram_arb_tag_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic                     i_push_tag,
    input  logic                     i_pop,
    output logic                     o_head_tag,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_tag = r_mem[r_rd_ptr];
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;

    // NOTE: tag storage is deliberately not reset; entries are only read
    // between the pointers, which are reset, so stale bits are never seen.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, routing responses by
// an in-order source tag. Define SRAM_ARB_RR_EN for round-robin tie-break.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_busy,
    output logic        arb_err
);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    sram_req_t               w_inst_bus;
    sram_req_t               w_data_bus;
    sram_req_t               w_sel_bus;
    logic                    w_sel_valid;
    logic                    w_sel_src;
    logic                    w_tie_src;
    logic                    w_mem_req;
    logic                    w_accept;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_head_tag;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    r_err;

    assign w_inst_bus = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
    assign w_data_bus = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};

`ifdef SRAM_ARB_RR_EN
    logic r_last_grant;

    assign w_tie_src = ~r_last_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= SRC_INST;
        end else if (w_accept) begin
            r_last_grant <= w_sel_src;
        end
    end
`else
    assign w_tie_src = DATA_PRIO ? SRC_DATA : SRC_INST;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a value held (no latch).
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_src   = SRC_INST;
        w_state_nxt = r_state;

        case (r_state)
            LOCK_I: begin
                w_sel_valid = inst_sram_req;
                w_sel_src   = SRC_INST;
            end
            LOCK_D: begin
                w_sel_valid = data_sram_req;
                w_sel_src   = SRC_DATA;
            end
            default: begin
                w_sel_valid = inst_sram_req | data_sram_req;
                if (inst_sram_req & data_sram_req) begin
                    w_sel_src = w_tie_src;
                end else begin
                    w_sel_src = data_sram_req ? SRC_DATA : SRC_INST;
                end
            end
        endcase

        // Full is judged on the registered count, so a same-cycle pop never frees a slot.
        w_mem_req = w_sel_valid & ~w_full & rstn;
        w_accept  = w_mem_req & mem_addr_ok;

        case (r_state)
            IDLE: begin
                if (w_mem_req & ~mem_addr_ok) begin
                    w_state_nxt = (w_sel_src == SRC_DATA) ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I, LOCK_D: begin
                // A dropped request is a flush: release without sending anything.
                if (~w_sel_valid | w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_sel_bus = (w_sel_src == SRC_DATA) ? w_data_bus : w_inst_bus;

    assign mem_req   = w_mem_req;
    assign mem_wr    = w_sel_bus.wr;
    assign mem_size  = w_sel_bus.size;
    assign mem_wstrb = w_sel_bus.wstrb;
    assign mem_addr  = w_sel_bus.addr;
    assign mem_wdata = w_sel_bus.wdata;

    assign inst_sram_addr_ok = w_accept & (w_sel_src == SRC_INST);
    assign data_sram_addr_ok = w_accept & (w_sel_src == SRC_DATA);

    sram_arb_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_accept),
        .i_push_tag (w_sel_src),
        .i_pop      (mem_data_ok),
        .o_head_tag (w_head_tag),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign inst_sram_data_ok = mem_data_ok & ~w_empty & (w_head_tag == SRC_INST);
    assign data_sram_data_ok = mem_data_ok & ~w_empty & (w_head_tag == SRC_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;
    assign arb_busy          = (w_count != '0);

    // A response with nothing outstanding means the bridge and arbiter lost sync.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (mem_data_ok & w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign arb_err = r_err;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: queue-based reference model checked
// every cycle, directed literal scenarios, then randomized traffic.
module tb_sram_bus_arbiter;

    localparam int DEPTH     = 4;
    localparam bit DATA_PRIO = 1'b1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        arb_busy, arb_err;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.DEPTH(DEPTH), .DATA_PRIO(DATA_PRIO)) dut (
        .clk(clk), .rstn(rstn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy), .arb_err(arb_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding tags as a queue, lock as "who owns the port".
    bit          m_tags[$];
    int          m_lock = 0;       // 0 none, 1 inst, 2 data
    bit          m_err = 1'b0;
    bit          m_last = 1'b0;    // 1 = data won the last acceptance
    bit          m_acc_i = 1'b0;
    bit          m_acc_d = 1'b0;
    int          cand;
    bit          full, exp_req, acc, exp_di, exp_dd;
    logic [70:0] exp_bus;

    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            check("rst_mem_req", 72'(mem_req), 72'(0));
            check("rst_i_addr_ok", 72'(inst_sram_addr_ok), 72'(0));
            check("rst_d_addr_ok", 72'(data_sram_addr_ok), 72'(0));
            check("rst_i_data_ok", 72'(inst_sram_data_ok), 72'(0));
            check("rst_d_data_ok", 72'(data_sram_data_ok), 72'(0));
            check("rst_busy", 72'(arb_busy), 72'(0));
            check("rst_err", 72'(arb_err), 72'(0));
            m_tags.delete();
            m_lock  = 0;
            m_err   = 1'b0;
            m_last  = 1'b0;
            m_acc_i = 1'b0;
            m_acc_d = 1'b0;
        end else begin
            full = (m_tags.size() == DEPTH);
            if (m_lock == 1)      cand = inst_sram_req ? 1 : 0;
            else if (m_lock == 2) cand = data_sram_req ? 2 : 0;
            else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_RR_EN
                cand = m_last ? 1 : 2;
`else
                cand = DATA_PRIO ? 2 : 1;
`endif
            end else cand = data_sram_req ? 2 : (inst_sram_req ? 1 : 0);

            exp_req = (cand != 0) && !full;
            acc     = exp_req && mem_addr_ok;
            check("mem_req", 72'(mem_req), 72'(exp_req));
            if (exp_req) begin
                exp_bus = (cand == 2)
                    ? {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}
                    : {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
                check("mem_bus", 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 72'(exp_bus));
            end
            check("i_addr_ok", 72'(inst_sram_addr_ok), 72'(acc && cand == 1));
            check("d_addr_ok", 72'(data_sram_addr_ok), 72'(acc && cand == 2));

            exp_di = mem_data_ok && (m_tags.size() > 0) && (m_tags[0] == 1'b0);
            exp_dd = mem_data_ok && (m_tags.size() > 0) && (m_tags[0] == 1'b1);
            check("i_data_ok", 72'(inst_sram_data_ok), 72'(exp_di));
            check("d_data_ok", 72'(data_sram_data_ok), 72'(exp_dd));
            check("i_rdata", 72'(inst_sram_rdata), 72'(mem_rdata));
            check("d_rdata", 72'(data_sram_rdata), 72'(mem_rdata));
            check("busy", 72'(arb_busy), 72'(m_tags.size() > 0));
            check("err", 72'(arb_err), 72'(m_err));

            if (mem_data_ok) begin
                if (m_tags.size() > 0) void'(m_tags.pop_front());
                else m_err = 1'b1;
            end
            if (acc) begin
                m_tags.push_back(cand == 2);
                m_last = (cand == 2);
            end
            if (m_lock != 0) begin
                if (cand == 0 || acc) m_lock = 0;
            end else if (exp_req && !mem_addr_ok) begin
                m_lock = cand;
            end
            m_acc_i = acc && (cand == 1);
            m_acc_d = acc && (cand == 2);
        end
    end

    task automatic set_inst(input bit req, input logic [31:0] addr);
        inst_sram_req   = req;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_wstrb = 4'hf;
        inst_sram_addr  = addr;
        inst_sram_wdata = ~addr;
    endtask

    task automatic set_data(input bit req, input bit wr, input logic [31:0] addr);
        data_sram_req   = req;
        data_sram_wr    = wr;
        data_sram_size  = 2'd2;
        data_sram_wstrb = wr ? 4'h3 : 4'h0;
        data_sram_addr  = addr;
        data_sram_wdata = addr ^ 32'h5a5a_5a5a;
    endtask

    task automatic bridge(input bit aok, input bit dok, input logic [31:0] rd);
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        tick(); rstn = 1'b0;
        tick(); rstn = 1'b1;
    endtask

    bit exp_d;

    initial begin
        rstn = 1'b0;
        set_inst(0, 32'h0);
        set_data(0, 0, 32'h0);
        bridge(0, 0, 32'h0);
        tick(); tick();
        #3 check("lit_reset_busy", 72'(arb_busy), 72'(0));
        tick(); rstn = 1'b1;

        // Simultaneous requests: data wins, inst follows next cycle.
        tick(); set_inst(1, 32'h1c00_0000); set_data(1, 1, 32'h8000_1000); bridge(1, 0, 0);
        #3 check("lit_prio_d_ok", 72'(data_sram_addr_ok), 72'(1));
        check("lit_prio_i_ok", 72'(inst_sram_addr_ok), 72'(0));
        check("lit_prio_addr", 72'(mem_addr), 72'(32'h8000_1000));
        tick(); set_data(0, 0, 32'h0);
        #3 check("lit_next_i_ok", 72'(inst_sram_addr_ok), 72'(1));
        check("lit_next_addr", 72'(mem_addr), 72'(32'h1c00_0000));
        tick(); set_inst(0, 32'h0); bridge(0, 1, 32'haaaa_0001);
        #3 check("lit_resp1_d", 72'(data_sram_data_ok), 72'(1));
        tick(); bridge(0, 1, 32'haaaa_0002);
        #3 check("lit_resp2_i", 72'(inst_sram_data_ok), 72'(1));
        tick(); bridge(0, 0, 0);

        // Stalled inst request keeps the port locked while data arrives.
        tick(); set_inst(1, 32'h1c00_0000);
        #3 check("lit_lock_addr0", 72'(mem_addr), 72'(32'h1c00_0000));
        tick(); set_data(1, 0, 32'h8000_2000);
        #3 check("lit_lock_addr1", 72'(mem_addr), 72'(32'h1c00_0000));
        check("lit_lock_d_ok", 72'(data_sram_addr_ok), 72'(0));
        tick();
        #3 check("lit_lock_addr2", 72'(mem_addr), 72'(32'h1c00_0000));
        tick(); bridge(1, 0, 0);
        #3 check("lit_lock_i_ok", 72'(inst_sram_addr_ok), 72'(1));
        tick(); set_inst(0, 32'h0);
        #3 check("lit_after_d_ok", 72'(data_sram_addr_ok), 72'(1));
        check("lit_after_addr", 72'(mem_addr), 72'(32'h8000_2000));
        tick(); set_data(0, 0, 32'h0); bridge(0, 1, 32'h3);
        tick(); bridge(0, 1, 32'h4);
        tick(); bridge(0, 0, 0);

        // Fill I,D,I,D; fifth request blocked; drain with a push+pop in the middle.
        for (int k = 0; k < 4; k++) begin
            tick(); bridge(1, 0, 0);
            set_inst(k % 2 == 0, 32'h1000 + 32'(k * 4));
            set_data(k % 2 == 1, 0, 32'h1000 + 32'(k * 4));
        end
        tick(); set_inst(1, 32'h2000); set_data(0, 0, 32'h0);
        #3 check("lit_full_req", 72'(mem_req), 72'(0));
        check("lit_full_i_ok", 72'(inst_sram_addr_ok), 72'(0));
        check("lit_full_busy", 72'(arb_busy), 72'(1));
        tick(); set_inst(0, 32'h0); bridge(1, 1, 32'h11);
        #3 check("lit_r11_i", 72'(inst_sram_data_ok), 72'(1));
        check("lit_r11_d", 72'(data_sram_data_ok), 72'(0));
        check("lit_r11_data", 72'(inst_sram_rdata), 72'(32'h11));
        tick(); bridge(1, 1, 32'h22);
        #3 check("lit_r22_d", 72'(data_sram_data_ok), 72'(1));
        tick(); set_inst(1, 32'h3000); bridge(1, 1, 32'h33);
        #3 check("lit_r33_i", 72'(inst_sram_data_ok), 72'(1));
        check("lit_pushpop_ok", 72'(inst_sram_addr_ok), 72'(1));
        tick(); set_inst(0, 32'h0); bridge(0, 1, 32'h44);
        #3 check("lit_r44_d", 72'(data_sram_data_ok), 72'(1));
        check("lit_r44_data", 72'(data_sram_rdata), 72'(32'h44));
        tick(); bridge(0, 1, 32'h55);
        #3 check("lit_r55_i", 72'(inst_sram_data_ok), 72'(1));
        tick(); bridge(0, 0, 0);
        #3 check("lit_drained", 72'(arb_busy), 72'(0));

        // Orphan response, then reset in the middle of a locked data request.
        tick(); bridge(0, 1, 32'hdead);
        #3 check("lit_orphan_i", 72'(inst_sram_data_ok), 72'(0));
        check("lit_orphan_d", 72'(data_sram_data_ok), 72'(0));
        tick(); bridge(0, 0, 0);
        #3 check("lit_err_set", 72'(arb_err), 72'(1));
        tick();
        #3 check("lit_err_held", 72'(arb_err), 72'(1));
        tick(); set_data(1, 1, 32'h8000_3000); bridge(1, 0, 0);
        tick(); set_data(1, 0, 32'h8000_3004); bridge(0, 0, 0);
        tick();
        #3 check("lit_lockd_addr", 72'(mem_addr), 72'(32'h8000_3004));
        tick(); rstn = 1'b0;
        #3 check("lit_rst_req", 72'(mem_req), 72'(0));
        check("lit_rst_busy", 72'(arb_busy), 72'(0));
        check("lit_rst_err", 72'(arb_err), 72'(0));
        tick(); rstn = 1'b1; set_data(0, 0, 32'h0);
        tick(); bridge(0, 1, 32'h77);
        #3 check("lit_late_d", 72'(data_sram_data_ok), 72'(0));
        tick(); bridge(0, 0, 0);
        #3 check("lit_late_err", 72'(arb_err), 72'(1));

        // Both requesting continuously from a fresh reset.
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            tick(); set_inst(1, 32'h1c00_0100 + 32'(k)); set_data(1, 0, 32'h8000_4000 + 32'(k)); bridge(1, 0, 0);
`ifdef SRAM_ARB_RR_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            #3 check("lit_tie_d", 72'(data_sram_addr_ok), 72'(exp_d));
            check("lit_tie_i", 72'(inst_sram_addr_ok), 72'(!exp_d));
        end
        tick(); set_inst(0, 32'h0); set_data(0, 0, 32'h0); bridge(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); bridge(0, 1, 32'hb0 + 32'(k));
        end
        tick(); bridge(0, 0, 0);

        // Randomized traffic against the model.
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (inst_sram_req && !m_acc_i) begin
                if ($urandom_range(0, 19) == 0) inst_sram_req = 1'b0;
            end else begin
                inst_sram_req   = ($urandom_range(0, 9) < 6);
                inst_sram_size  = 2'($urandom_range(0, 2));
                inst_sram_wstrb = 4'($urandom);
                inst_sram_addr  = $urandom;
                inst_sram_wdata = $urandom;
            end
            if (data_sram_req && !m_acc_d) begin
                if ($urandom_range(0, 19) == 0) data_sram_req = 1'b0;
            end else begin
                data_sram_req   = ($urandom_range(0, 9) < 6);
                data_sram_wr    = 1'($urandom);
                data_sram_size  = 2'($urandom_range(0, 2));
                data_sram_wstrb = 4'($urandom);
                data_sram_addr  = $urandom;
                data_sram_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
        end
        tick(); set_inst(0, 32'h0); set_data(0, 0, 32'h0); bridge(0, 0, 0);
        for (int k = 0; k < DEPTH + 2; k++) begin
            tick(); bridge(0, m_tags.size() > 0, 32'hc0 + 32'(k));
        end
        tick(); bridge(0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
